// File: rtl/alu_wb_stage.sv
// rtl/alu_wb_stage.sv - ALU write-back stage: 2-entry result FIFO, flag register, branch condition evaluator
// Optional macro WB_FLAG_BYPASS_EN: cond_true sees in_flags when a flag update is accepted this cycle.
module alu_wb_stage #(
    parameter int DATA_W = 16,
    parameter int DEST_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [3:0]        in_flags,
    input  logic [DEST_W-1:0] in_dest,
    input  logic              in_wr_en,
    input  logic              in_flag_upd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [DEST_W-1:0] out_dest,
    output logic [3:0]        flags_q,
    input  logic [3:0]        cond,
    output logic              cond_true
);

    localparam int ENTRY_W = DATA_W + DEST_W;

    logic [ENTRY_W-1:0] mem [0:1];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         count;
    logic               in_xfer;
    logic               enq;
    logic               deq;
    logic [ENTRY_W-1:0] head;
    logic [3:0]         eval_flags;
    logic               z, n, c, o;

    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign in_xfer   = in_valid && in_ready;
    assign enq       = in_xfer && in_wr_en;
    assign deq       = out_valid && out_ready;
    assign head      = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= 2'd0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            flags_q <= 4'd0;
        end else begin
            if (enq) wr_ptr <= ~wr_ptr;
            if (deq) rd_ptr <= ~rd_ptr;
            if (enq && !deq)
                count <= count + 2'd1;
            else if (deq && !enq)
                count <= count - 2'd1;
            // Flag commit is independent of whether the result itself is queued.
            if (in_xfer && in_flag_upd) flags_q <= in_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) mem[wr_ptr] <= {in_result, in_dest};
    end

    always_comb begin
        out_result = '0;
        out_dest   = '0;
        if (out_valid) begin
            out_result = head[ENTRY_W-1:DEST_W];
            out_dest   = head[DEST_W-1:0];
        end
    end

    always_comb begin
        eval_flags = flags_q;
`ifdef WB_FLAG_BYPASS_EN
        if (in_xfer && in_flag_upd) eval_flags = in_flags;
`endif
    end

    assign z = eval_flags[3];
    assign n = eval_flags[2];
    assign c = eval_flags[1];
    assign o = eval_flags[0];

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            4'd0:    cond_true = 1'b1;
            4'd1:    cond_true = z;
            4'd2:    cond_true = !z;
            4'd3:    cond_true = n;
            4'd4:    cond_true = !n;
            4'd5:    cond_true = c;
            4'd6:    cond_true = !c;
            4'd7:    cond_true = o;
            4'd8:    cond_true = !o;
            4'd9:    cond_true = !z && (n == o);
            4'd10:   cond_true = (n == o);
            4'd11:   cond_true = (n != o);
            4'd12:   cond_true = z || (n != o);
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_alu_wb_stage.sv
// tb/tb_alu_wb_stage.sv - self-checking bench for alu_wb_stage against a queue-based reference model
module tb_alu_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_result = '0;
    logic [3:0]  in_flags = '0;
    logic [2:0]  in_dest = '0;
    logic        in_wr_en = 1'b0;
    logic        in_flag_upd = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_result;
    logic [2:0]  out_dest;
    logic [3:0]  flags_q;
    logic [3:0]  cond = '0;
    logic        cond_true;

    int total = 0;
    int bad = 0;

    logic [18:0] model_q[$];
    logic [3:0]  model_flags = '0;

    alu_wb_stage #(.DATA_W(16), .DEST_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_flags(in_flags), .in_dest(in_dest),
        .in_wr_en(in_wr_en), .in_flag_upd(in_flag_upd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_dest(out_dest),
        .flags_q(flags_q), .cond(cond), .cond_true(cond_true)
    );

    always #5 clk = ~clk;

    function automatic bit cond_ref(input logic [3:0] c, input logic [3:0] f);
        bit z, n, cy, o;
        z = f[3]; n = f[2]; cy = f[1]; o = f[0];
        case (c)
            4'd0:  return 1'b1;
            4'd1:  return z;
            4'd2:  return !z;
            4'd3:  return n;
            4'd4:  return !n;
            4'd5:  return cy;
            4'd6:  return !cy;
            4'd7:  return o;
            4'd8:  return !o;
            4'd9:  return !z && (n == o);
            4'd10: return n == o;
            4'd11: return n != o;
            4'd12: return z || (n != o);
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: drive, check settled outputs, then advance one rising edge.
    task automatic step(input bit v, input logic [15:0] r, input logic [2:0] d, input bit wr,
                        input bit fu, input logic [3:0] f, input bit ordy, input logic [3:0] cnd);
        bit exp_ready, exp_valid, acc;
        logic [3:0] ef;
        in_valid = v; in_result = r; in_dest = d; in_wr_en = wr;
        in_flag_upd = fu; in_flags = f; out_ready = ordy; cond = cnd;
        #1;
        exp_ready = model_q.size() < 2;
        exp_valid = model_q.size() != 0;
        acc = v && exp_ready;
        ef = model_flags;
`ifdef WB_FLAG_BYPASS_EN
        if (acc && fu) ef = f;
`endif
        chk("in_ready", in_ready, exp_ready);
        chk("out_valid", out_valid, exp_valid);
        chk("out_result", out_result, exp_valid ? model_q[0][18:3] : 16'h0);
        chk("out_dest", out_dest, exp_valid ? model_q[0][2:0] : 3'h0);
        chk("flags_q", flags_q, model_flags);
        chk("cond_true", cond_true, cond_ref(cnd, ef));
        @(posedge clk);
        if (exp_valid && ordy) void'(model_q.pop_front());
        if (acc && wr) model_q.push_back({r, d});
        if (acc && fu) model_flags = f;
        @(negedge clk);
    endtask

    initial begin
        // Reset state while rst_n is held low
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_result", out_result, 16'h0);
        chk("rst_flags", flags_q, 4'h0);
        chk("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single push, latency 1, then drains
        step(1, 16'h1234, 3'd5, 1, 0, 4'h0, 1, 4'd0);
        step(0, 16'h0, 3'd0, 0, 0, 4'h0, 1, 4'd0);
        step(0, 16'h0, 3'd0, 0, 0, 4'h0, 1, 4'd0);

        // Back-to-back pushes with stalled output, third held until space frees
        step(1, 16'h0001, 3'd1, 1, 0, 4'h0, 0, 4'd0);
        step(1, 16'h0002, 3'd2, 1, 0, 4'h0, 0, 4'd0);
        step(1, 16'h0003, 3'd3, 1, 0, 4'h0, 0, 4'd0);
        step(1, 16'h0003, 3'd3, 1, 0, 4'h0, 1, 4'd0);
        step(1, 16'h0003, 3'd3, 1, 0, 4'h0, 1, 4'd0);
        step(0, 16'h0, 3'd0, 0, 0, 4'h0, 1, 4'd0);
        step(0, 16'h0, 3'd0, 0, 0, 4'h0, 1, 4'd0);

        // Count 1 with simultaneous push and pop
        step(1, 16'h0055, 3'd4, 1, 0, 4'h0, 0, 4'd0);
        step(1, 16'h00AA, 3'd6, 1, 0, 4'h0, 1, 4'd0);
        step(0, 16'h0, 3'd0, 0, 0, 4'h0, 1, 4'd0);
        step(0, 16'h0, 3'd0, 0, 0, 4'h0, 1, 4'd0);

        // Flag-only transfer, then EQ / NE
        step(1, 16'h7777, 3'd7, 0, 1, 4'b1000, 1, 4'd1);
        step(0, 16'h0, 3'd0, 0, 0, 4'h0, 1, 4'd1);
        step(0, 16'h0, 3'd0, 0, 0, 4'h0, 1, 4'd2);

        // Flag bypass behaviour on MI
        step(1, 16'h0, 3'd0, 0, 1, 4'b0000, 1, 4'd0);
        step(1, 16'h0, 3'd0, 0, 1, 4'b0100, 1, 4'd3);
        step(0, 16'h0, 3'd0, 0, 0, 4'h0, 1, 4'd3);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 16'($urandom), 3'($urandom), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1, 4'($urandom), $urandom_range(0, 2) != 0, 4'($urandom));
        end
        for (int i = 0; i < 3; i++) step(0, 16'h0, 3'd0, 0, 0, 4'h0, 1, 4'd0);

        // Reset mid-operation with two entries buffered
        step(1, 16'h1111, 3'd1, 1, 1, 4'b0011, 0, 4'd0);
        step(1, 16'h2222, 3'd2, 1, 1, 4'b0011, 0, 4'd0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_out_result", out_result, 16'h0);
        chk("midrst_flags", flags_q, 4'h0);
        chk("midrst_in_ready", in_ready, 1'b1);
        model_q.delete();
        model_flags = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 16'hBEEF, 3'd3, 1, 0, 4'h0, 1, 4'd0);
        step(0, 16'h0, 3'd0, 0, 0, 4'h0, 1, 4'd0);
        step(0, 16'h0, 3'd0, 0, 0, 4'h0, 1, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
